// File: rtl/nzcv_gen_if.sv
// Bus between the ALU writeback stage and the NZCV flag generator.
// The master drives the result/handshake; the slave returns the flag state.
interface nzcv_gen_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic             s;
    logic             cond_pass;
    logic [1:0]       op;
    logic [WIDTH-1:0] result;
    logic             alu_c;
    logic             alu_v;
    logic             sh_c;
    logic             hold;
    logic             flush;
    logic [3:0]       nzcv;
    logic [3:0]       nzcv_fwd;
    logic             flag_pending;
    logic [7:0]       update_cnt;

    modport master (
        output in_valid, s, cond_pass, op, result, alu_c, alu_v, sh_c, hold, flush,
        input  in_ready, nzcv, nzcv_fwd, flag_pending, update_cnt
    );

    modport slave (
        input  in_valid, s, cond_pass, op, result, alu_c, alu_v, sh_c, hold, flush,
        output in_ready, nzcv, nzcv_fwd, flag_pending, update_cnt
    );
endinterface

// File: rtl/nzcv_gen.sv
// NZCV flag generator: one-entry stage register between ALU result and the
// committed condition flags, with a bypass of the pending update.
module nzcv_gen #(
    parameter int WIDTH = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    nzcv_gen_if.slave   bus
);

    logic       r_p_valid;
    logic       r_p_we;
    logic [3:0] r_p_nzcv;
    logic [3:0] r_p_mask;
    logic [3:0] r_nzcv;
    logic [7:0] r_update_cnt;

    logic       w_ready;
    logic       w_xfer;
    logic       w_retire;
    logic       w_commit;
    logic       w_we;
    logic       w_zero;
    logic [3:0] w_flags;
    logic [3:0] w_mask;
    logic [3:0] w_merged;

    assign w_ready  = !bus.flush && (!r_p_valid || !bus.hold);
    assign w_xfer   = bus.in_valid && w_ready && !bus.flush;
    assign w_retire = r_p_valid && !bus.hold && !bus.flush;
    assign w_commit = w_retire && r_p_we;
    assign w_we     = bus.cond_pass && (bus.s || (bus.op == 2'b11));
    assign w_merged = (r_p_nzcv & r_p_mask) | (r_nzcv & ~r_p_mask);

    // Flag candidates for the incoming result; logical ops leave V untouched.
    always_comb begin
        w_zero  = (bus.result == {WIDTH{1'b0}});
        w_flags = 4'b0000;
        w_mask  = 4'b1111;
        case (bus.op)
            2'b00: begin
                w_flags = {bus.result[WIDTH-1], w_zero, bus.sh_c, bus.alu_v};
                w_mask  = 4'b1110;
            end
            2'b01, 2'b10: begin
                w_flags = {bus.result[WIDTH-1], w_zero, bus.alu_c, bus.alu_v};
                w_mask  = 4'b1111;
            end
            2'b11: begin
                w_flags = bus.result[WIDTH-1 -: 4];
                w_mask  = 4'b1111;
            end
            default: begin
                w_flags = 4'b0000;
                w_mask  = 4'b1111;
            end
        endcase
    end

    // Stage register, committed flags and update counter; flush beats hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_p_valid    <= 1'b0;
            r_p_we       <= 1'b0;
            r_p_nzcv     <= 4'b0000;
            r_p_mask     <= 4'b0000;
            r_nzcv       <= 4'b0000;
            r_update_cnt <= 8'd0;
        end else if (bus.flush) begin
            r_p_valid <= 1'b0;
        end else begin
            if (w_commit) begin
                r_nzcv       <= w_merged;
                r_update_cnt <= r_update_cnt + 8'd1;
            end
            if (w_xfer) begin
                r_p_valid <= 1'b1;
                r_p_we    <= w_we;
                r_p_nzcv  <= w_flags;
                r_p_mask  <= w_mask;
            end else if (w_retire) begin
                r_p_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready     = w_ready;
    assign bus.nzcv         = r_nzcv;
    assign bus.flag_pending = r_p_valid && r_p_we;
    assign bus.nzcv_fwd     = (r_p_valid && r_p_we) ? w_merged : r_nzcv;
    assign bus.update_cnt   = r_update_cnt;

endmodule

// File: tb/tb_nzcv_gen.sv
// Bench for nzcv_gen: directed corner cases plus a randomized stream checked
// against a queue-based reference model of the flag pipeline.
module tb_nzcv_gen;

    logic clk;
    logic rst;

    nzcv_gen_if #(.WIDTH(32)) bus ();

    nzcv_gen #(.WIDTH(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [1:0] op;
        logic [3:0] f;
    } ent_t;

    ent_t pq[$];
    logic [3:0] m_nzcv;
    int         m_cnt;
    int         n_pass;
    int         n_total;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Applying an update: logical ops keep the previous V, everything else overwrites.
    function automatic logic [3:0] apply(input ent_t e, input logic [3:0] cur);
        if (e.op == 2'b00) return {e.f[3:1], cur[0]};
        return e.f;
    endfunction

    task automatic cyc(input logic v, input logic s, input logic cp, input logic [1:0] op,
                       input logic [31:0] res, input logic ac, input logic av,
                       input logic sc, input logic hold, input logic flush);
        logic e_ready;
        logic e_pend;
        logic [3:0] e_fwd;
        ent_t e;
        @(negedge clk);
        bus.in_valid = v; bus.s = s; bus.cond_pass = cp; bus.op = op; bus.result = res;
        bus.alu_c = ac; bus.alu_v = av; bus.sh_c = sc; bus.hold = hold; bus.flush = flush;
        #1;
        e_ready = !flush && (pq.size() == 0 || !hold);
        e_pend  = (pq.size() != 0) && pq[0].we;
        e_fwd   = e_pend ? apply(pq[0], m_nzcv) : m_nzcv;
        chk("in_ready", {7'd0, bus.in_ready}, {7'd0, e_ready});
        chk("flag_pending", {7'd0, bus.flag_pending}, {7'd0, e_pend});
        chk("nzcv_fwd", {4'd0, bus.nzcv_fwd}, {4'd0, e_fwd});
        chk("nzcv_pre", {4'd0, bus.nzcv}, {4'd0, m_nzcv});
        chk("cnt_pre", bus.update_cnt, m_cnt[7:0]);
        if (flush) begin
            pq.delete();
        end else begin
            if (pq.size() != 0 && !hold) begin
                if (pq[0].we) begin
                    m_nzcv = apply(pq[0], m_nzcv);
                    m_cnt  = (m_cnt + 1) % 256;
                end
                void'(pq.pop_front());
            end
            if (v && e_ready) begin
                e.we = cp && (s || op == 2'b11);
                e.op = op;
                if (op == 2'b11) e.f = res[31:28];
                else e.f = {res[31], res == 32'd0, (op == 2'b00) ? sc : ac, av};
                pq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk("nzcv_post", {4'd0, bus.nzcv}, {4'd0, m_nzcv});
        chk("cnt_post", bus.update_cnt, m_cnt[7:0]);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset: the outputs must clear before any clock edge.
    task automatic rst_pulse();
        bus.in_valid = 1'b0; bus.hold = 1'b0; bus.flush = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_nzcv", {4'd0, bus.nzcv}, 8'h00);
        chk("rst_cnt", bus.update_cnt, 8'h00);
        chk("rst_pend", {7'd0, bus.flag_pending}, 8'h00);
        chk("rst_ready", {7'd0, bus.in_ready}, 8'h01);
        chk("rst_fwd", {4'd0, bus.nzcv_fwd}, 8'h00);
        pq.delete();
        m_nzcv = 4'b0000;
        m_cnt  = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0; m_nzcv = 4'b0000; m_cnt = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.s = 1'b0; bus.cond_pass = 1'b0; bus.op = 2'b00;
        bus.result = 32'd0; bus.alu_c = 1'b0; bus.alu_v = 1'b0; bus.sh_c = 1'b0;
        bus.hold = 1'b0; bus.flush = 1'b0;
        #7;
        chk("reset_nzcv", {4'd0, bus.nzcv}, 8'h00);
        chk("reset_cnt", bus.update_cnt, 8'h00);
        chk("reset_pend", {7'd0, bus.flag_pending}, 8'h00);
        chk("reset_ready", {7'd0, bus.in_ready}, 8'h01);
        @(negedge clk);
        rst = 1'b0;

        // Arithmetic zero result with carry.
        cyc(1'b1, 1'b1, 1'b1, 2'b01, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("arith_nzcv", {4'd0, bus.nzcv}, 8'h06);
        chk("arith_cnt", bus.update_cnt, 8'd1);

        // Logical op keeps V set by an MSR write.
        cyc(1'b1, 1'b0, 1'b1, 2'b11, 32'h1000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'b00, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("logic_nzcv", {4'd0, bus.nzcv}, 8'h0B);

        // MSR write, then a condition-failed MSR that must not change anything.
        cyc(1'b1, 1'b0, 1'b1, 2'b11, 32'hA000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("msr_nzcv", {4'd0, bus.nzcv}, 8'h0A);
        cyc(1'b1, 1'b0, 1'b0, 2'b11, 32'h5000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("msr_nc_nzcv", {4'd0, bus.nzcv}, 8'h0A);
        chk("msr_nc_cnt", bus.update_cnt, 8'd4);

        // Held update: bypass shows new flags, commit waits for hold release.
        cyc(1'b1, 1'b1, 1'b1, 2'b01, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 2'b01, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("hold_ready", {7'd0, bus.in_ready}, 8'h00);
            chk("hold_pend", {7'd0, bus.flag_pending}, 8'h01);
            chk("hold_fwd", {4'd0, bus.nzcv_fwd}, 8'h09);
            chk("hold_nzcv", {4'd0, bus.nzcv}, 8'h0A);
        end
        idle();
        chk("hold_commit", {4'd0, bus.nzcv}, 8'h09);
        chk("hold_cnt", bus.update_cnt, 8'd5);

        // Flush together with hold discards the pending update.
        cyc(1'b1, 1'b1, 1'b1, 2'b01, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("flush_pend", {7'd0, bus.flag_pending}, 8'h00);
        chk("flush_nzcv", {4'd0, bus.nzcv}, 8'h09);
        chk("flush_ready", {7'd0, bus.in_ready}, 8'h00);
        idle();
        chk("flush_after", {4'd0, bus.nzcv}, 8'h09);
        chk("flush_cnt", bus.update_cnt, 8'd5);

        // Counter wrap over 256 back-to-back flag-writing transfers.
        rst_pulse();
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 2'($urandom_range(0, 3)), $urandom,
                1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        end
        chk("wrap_255", bus.update_cnt, 8'd255);
        idle();
        chk("wrap_0", bus.update_cnt, 8'd0);

        // Randomized stream with hold, flush and a mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) rst_pulse();
            cyc(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                1'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nzcv_gen.md
NZCV_GEN -- requirements
Module: NZCV_GEN

Interface
REQ-001 SHALL have parameter: WIDTH, 32, ALU result width (>= 4).
REQ-002 SHALL have port: CLK  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: IN_VALID  input  1  ALU result presented this cycle.
REQ-005 SHALL have port: IN_READY  output  1  block accepts the presented result.
REQ-006 SHALL have port: S  input  1  set-flags bit of the instruction.
REQ-007 SHALL have port: COND_PASS  input  1  instruction condition passed.
REQ-008 SHALL have port: OP  input  2  flag class: 00 logical, 01 arithmetic, 10 compare/test, 11 MSR flag write.
REQ-009 SHALL have port: RESULT  input  WIDTH  ALU result, or MSR operand when OP=11.
REQ-010 SHALL have port: ALU_C  input  1  adder carry out.
REQ-011 SHALL have port: ALU_V  input  1  adder overflow.
REQ-012 SHALL have port: SH_C  input  1  shifter carry out.
REQ-013 SHALL have port: HOLD  input  1  downstream stall; blocks commit.
REQ-014 SHALL have port: FLUSH  input  1  discard pending update.
REQ-015 SHALL have port: NZCV  output  4  committed flags {N,Z,C,V}, registered.
REQ-016 SHALL have port: NZCV_FWD  output  4  flags after pending commit (bypass), combinational.
REQ-017 SHALL have port: FLAG_PENDING  output  1  a flag-writing update is held in the stage register.
REQ-018 SHALL have port: UPDATE_CNT  output  8  count of committed flag updates.

Function
REQ-019 SHALL accept a result when IN_VALID && IN_READY && !FLUSH (a "transfer").
REQ-020 SHALL drive IN_READY = !FLUSH && (!P_VALID || !HOLD), P_VALID being the one-entry stage register valid bit.
REQ-021 SHALL on transfer load the stage: P_VALID=1; P_WE = COND_PASS && (S || OP==11); P_NZCV and P_MASK per REQ-022..024.
REQ-022 SHALL compute, OP 00/01/10: N=RESULT[WIDTH-1], Z=(RESULT==0); C=SH_C for OP 00, else ALU_C; V=ALU_V.
REQ-023 SHALL compute, OP 11: P_NZCV = RESULT[WIDTH-1:WIDTH-4].
REQ-024 SHALL set P_MASK=1110 for OP 00 (V preserved), else 1111.
REQ-025 SHALL commit when P_VALID && P_WE && !HOLD && !FLUSH: NZCV <= (P_NZCV & P_MASK) | (NZCV & ~P_MASK); UPDATE_CNT increments.
REQ-026 SHALL retire an entry (P_VALID cleared unless refilled same cycle) when P_VALID && !HOLD && !FLUSH, whether or not P_WE.
REQ-027 SHALL allow retire and transfer in the same cycle; latency transfer->NZCV update is exactly 1 cycle with HOLD low.
REQ-028 SHALL, while HOLD high, keep stage contents and NZCV unchanged and deassert IN_READY if P_VALID.
REQ-029 SHALL on FLUSH clear P_VALID next edge, perform no commit, accept no transfer; FLUSH overrides HOLD.
REQ-030 SHALL drive NZCV_FWD = FLAG_PENDING ? (P_NZCV & P_MASK)|(NZCV & ~P_MASK) : NZCV.
REQ-031 SHALL drive FLAG_PENDING = P_VALID && P_WE.
REQ-032 SHALL wrap UPDATE_CNT 255->0 without error indication.
REQ-033 SHALL never change NZCV for COND_PASS=0 or S=0 with OP!=11.

Reset
REQ-034 SHALL on RST asserted, immediately and asynchronously, set NZCV=0000, P_VALID=0, P_WE=0, P_NZCV=0000, P_MASK=0000, UPDATE_CNT=0; IN_READY=1 once FLUSH low.
REQ-035 SHALL discard a pending update when RST asserts mid-operation; first transfer allowed on first edge after RST deasserts.

Verification
REQ-036 SHALL cover: OP=01,S=1,COND_PASS=1,RESULT=0,ALU_C=1,ALU_V=0 -> next cycle NZCV=0110, UPDATE_CNT=1.
REQ-037 SHALL cover: NZCV=0001, OP=00,S=1,RESULT=0x80000000,SH_C=1 -> NZCV=1011 (V kept).
REQ-038 SHALL cover: OP=11,COND_PASS=1,S=0,RESULT=0xA0000000 -> NZCV=1010; same with COND_PASS=0 -> NZCV unchanged, UPDATE_CNT unchanged.
REQ-039 SHALL cover: pending update with HOLD=1 for 3 cycles -> IN_READY=0, FLAG_PENDING=1, NZCV_FWD=new value, NZCV old; HOLD drop -> commit next edge.
REQ-040 SHALL cover: pending update then FLUSH=1 together with HOLD=1 -> P_VALID=0, NZCV unchanged, IN_READY=0 that cycle.
REQ-041 SHALL cover: 256 back-to-back flag-writing transfers -> UPDATE_CNT returns to 0; RST mid-stream -> NZCV=0000 without clock edge.
